// File: rtl/fu_result_buffer.sv
// Per-FU result queue feeding the two-lane CDB arbiter: captures FU results,
// requests the bus with the oldest entry and pops it when either lane grants this FU.
module fu_result_buffer #(
    parameter int FU_ID  = 0,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       fu_valid,
    input  logic [DATA_W-1:0]          fu_value,
    input  logic [TAG_W-1:0]           fu_tag,
    output logic                       fu_ready,
    input  logic [4:0]                 grant_num_0,
    input  logic [4:0]                 grant_num_1,
    input  logic                       grant_en_0,
    input  logic                       grant_en_1,
    output logic                       result_valid,
    output logic [DATA_W-1:0]          result_value,
    output logic [TAG_W-1:0]           result_tag,
    output logic                       granted_lane,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]       FU_NUM = 5'(FU_ID);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_value [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic             w_valid;
    logic             w_ready;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_valid = (r_count != '0);
    assign w_ready = (r_count != FULL);
    assign w_hit0  = grant_en_0 & (grant_num_0 == FU_NUM);
    assign w_hit1  = grant_en_1 & (grant_num_1 == FU_NUM);
    assign w_push  = fu_valid & w_ready;
    assign w_pop   = w_valid & (w_hit0 | w_hit1);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            r_count <= w_count_nxt;
        end
    end

    // Storage is not reset; outputs are masked by w_valid instead.
    always_ff @(posedge clock) begin
        if (w_push && !squash) begin
            r_value[r_tail] <= fu_value;
            r_tag[r_tail]   <= fu_tag;
        end
    end

    always @(posedge clock) begin
        if (reset && !squash) begin
            assert (!(w_pop && r_count == '0));
            assert (!(w_push && r_count == FULL));
        end
        assert (r_count <= FULL);
    end

    assign fu_ready     = w_ready;
    assign result_valid = w_valid;
    assign result_value = w_valid ? r_value[r_head] : '0;
    assign result_tag   = w_valid ? r_tag[r_head] : '0;
    assign granted_lane = w_hit1 & ~w_hit0 & w_valid;
    assign count        = r_count;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer: vector table on a DEPTH=2 instance,
// queue-model wrap sequence on a DEPTH=3 instance, and an async mid-stream reset.
module tb_fu_result_buffer;

    logic clk;
    logic rst_n;

    logic        a_sq, a_fv, a_ge0, a_ge1, a_rdy, a_rv, a_gl;
    logic [31:0] a_val, a_rval;
    logic [5:0]  a_tag, a_rtag;
    logic [4:0]  a_gn0, a_gn1;
    logic [1:0]  a_cnt;

    logic        b_sq, b_fv, b_ge0, b_ge1, b_rdy, b_rv, b_gl;
    logic [31:0] b_val, b_rval;
    logic [5:0]  b_tag, b_rtag;
    logic [4:0]  b_gn0, b_gn1;
    logic [1:0]  b_cnt;

    int checks;
    int failures;

    fu_result_buffer #(.FU_ID(4), .DATA_W(32), .TAG_W(6), .DEPTH(2)) u_a (
        .clock(clk), .reset(rst_n), .squash(a_sq),
        .fu_valid(a_fv), .fu_value(a_val), .fu_tag(a_tag), .fu_ready(a_rdy),
        .grant_num_0(a_gn0), .grant_num_1(a_gn1), .grant_en_0(a_ge0), .grant_en_1(a_ge1),
        .result_valid(a_rv), .result_value(a_rval), .result_tag(a_rtag),
        .granted_lane(a_gl), .count(a_cnt)
    );

    fu_result_buffer #(.FU_ID(4), .DATA_W(32), .TAG_W(6), .DEPTH(3)) u_b (
        .clock(clk), .reset(rst_n), .squash(b_sq),
        .fu_valid(b_fv), .fu_value(b_val), .fu_tag(b_tag), .fu_ready(b_rdy),
        .grant_num_0(b_gn0), .grant_num_1(b_gn1), .grant_en_0(b_ge0), .grant_en_1(b_ge1),
        .result_valid(b_rv), .result_value(b_rval), .result_tag(b_rtag),
        .granted_lane(b_gl), .count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sq;
        logic       fv;
        logic [5:0] tg;
        logic [4:0] gn0;
        logic       ge0;
        logic [4:0] gn1;
        logic       ge1;
        logic       e_rdy;
        logic       e_rv;
        logic [5:0] e_tag;
        logic       e_gl;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic sq, input logic fv, input logic [5:0] tg,
                                input logic [4:0] gn0, input logic ge0,
                                input logic [4:0] gn1, input logic ge1,
                                input logic rdy, input logic rv, input logic [5:0] etg,
                                input logic gl, input logic [1:0] cnt);
        vec_t v;
        v.sq = sq; v.fv = fv; v.tg = tg;
        v.gn0 = gn0; v.ge0 = ge0; v.gn1 = gn1; v.ge1 = ge1;
        v.e_rdy = rdy; v.e_rv = rv; v.e_tag = etg; v.e_gl = gl; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] val_of(input logic [5:0] t);
        return 32'hA500_0000 | {26'd0, t};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int          q[$];
    int          nt;
    logic        m_push, m_pop;
    logic [31:0] exp_val;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        a_sq = 0; a_fv = 0; a_val = '0; a_tag = '0; a_gn0 = '0; a_ge0 = 0; a_gn1 = '0; a_ge1 = 0;
        b_sq = 0; b_fv = 0; b_val = '0; b_tag = '0; b_gn0 = '0; b_ge0 = 0; b_gn1 = '0; b_ge1 = 0;

        vecs[0]  = mk(0, 1,  5, 0, 0, 0, 0,  1, 0,  0, 0, 0);
        vecs[1]  = mk(0, 1,  9, 0, 0, 0, 0,  1, 1,  5, 0, 1);
        vecs[2]  = mk(0, 1,  7, 0, 0, 0, 0,  0, 1,  5, 0, 2);
        vecs[3]  = mk(0, 0,  0, 4, 0, 0, 0,  0, 1,  5, 0, 2);
        vecs[4]  = mk(0, 0,  0, 0, 0, 4, 1,  0, 1,  5, 1, 2);
        vecs[5]  = mk(0, 1, 12, 4, 1, 0, 0,  1, 1,  9, 0, 1);
        vecs[6]  = mk(0, 0,  0, 0, 0, 0, 0,  1, 1, 12, 0, 1);
        vecs[7]  = mk(0, 1,  3, 0, 0, 3, 1,  1, 1, 12, 0, 1);
        vecs[8]  = mk(1, 1, 14, 4, 1, 0, 0,  0, 1, 12, 0, 2);
        vecs[9]  = mk(0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0, 0);
        vecs[10] = mk(0, 0,  0, 4, 1, 4, 1,  1, 0,  0, 0, 0);
        vecs[11] = mk(0, 1,  1, 0, 0, 0, 0,  1, 0,  0, 0, 0);
        vecs[12] = mk(0, 1,  2, 0, 0, 0, 0,  1, 1,  1, 0, 1);
        vecs[13] = mk(0, 0,  0, 4, 1, 4, 1,  0, 1,  1, 0, 2);
        vecs[14] = mk(0, 0,  0, 0, 0, 0, 0,  1, 1,  2, 0, 1);
        vecs[15] = mk(1, 1,  6, 0, 0, 4, 1,  1, 1,  2, 1, 1);
        vecs[16] = mk(0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0, 0);

        #12;
        check("reset_count",   64'(a_cnt),  64'(0));
        check("reset_valid",   64'(a_rv),   64'(0));
        check("reset_ready",   64'(a_rdy),  64'(1));
        check("reset_value",   64'(a_rval), 64'(0));
        check("reset_tag",     64'(a_rtag), 64'(0));
        check("reset_granted", 64'(a_gl),   64'(0));
        #2 rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            a_sq = vecs[i].sq; a_fv = vecs[i].fv; a_tag = vecs[i].tg; a_val = val_of(vecs[i].tg);
            a_gn0 = vecs[i].gn0; a_ge0 = vecs[i].ge0; a_gn1 = vecs[i].gn1; a_ge1 = vecs[i].ge1;
            #4;
            exp_val = vecs[i].e_rv ? val_of(vecs[i].e_tag) : 32'd0;
            check($sformatf("v%0d_ready", i),   64'(a_rdy),  64'(vecs[i].e_rdy));
            check($sformatf("v%0d_valid", i),   64'(a_rv),   64'(vecs[i].e_rv));
            check($sformatf("v%0d_tag", i),     64'(a_rtag), 64'(vecs[i].e_tag));
            check($sformatf("v%0d_value", i),   64'(a_rval), 64'(exp_val));
            check($sformatf("v%0d_granted", i), 64'(a_gl),   64'(vecs[i].e_gl));
            check($sformatf("v%0d_count", i),   64'(a_cnt),  64'(vecs[i].e_cnt));
            next_cycle();
        end
        a_sq = 0; a_fv = 0; a_ge0 = 0; a_ge1 = 0;

        // DEPTH=3 instance: seven pushes through three slots, checked against a queue model.
        nt = 20;
        b_gn0 = 5'd4;
        for (int i = 0; i < 14; i++) begin
            b_fv  = (nt < 27);
            b_tag = 6'(nt);
            b_val = val_of(6'(nt));
            b_ge0 = ((i >= 3) && (i % 2 == 1)) || (i >= 9);
            #4;
            check($sformatf("w%0d_count", i), 64'(b_cnt), 64'(q.size()));
            check($sformatf("w%0d_ready", i), 64'(b_rdy), 64'(q.size() < 3));
            check($sformatf("w%0d_valid", i), 64'(b_rv),  64'(q.size() != 0));
            if (q.size() > 0) begin
                check($sformatf("w%0d_tag", i),   64'(b_rtag), 64'(q[0]));
                check($sformatf("w%0d_value", i), 64'(b_rval), 64'(val_of(6'(q[0]))));
            end
            m_push = b_fv && (q.size() < 3);
            m_pop  = b_ge0 && (q.size() > 0);
            next_cycle();
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(nt);
                nt++;
            end
        end
        b_fv = 0; b_ge0 = 0;
        check("wrap_all_pushed", 64'(nt), 64'(27));

        // Async reset mid-stream with two entries held.
        a_fv = 1; a_tag = 6'd33; a_val = val_of(6'd33);
        next_cycle();
        a_tag = 6'd34; a_val = val_of(6'd34);
        next_cycle();
        a_fv = 0;
        #1;
        check("midrst_pre_count", 64'(a_cnt), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(a_cnt), 64'(0));
        check("midrst_valid", 64'(a_rv),  64'(0));
        check("midrst_ready", 64'(a_rdy), 64'(1));
        check("midrst_tag",   64'(a_rtag), 64'(0));
        #2 rst_n = 1'b1;
        next_cycle();
        check("post_rst_count", 64'(a_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
